// File: rtl/axi_stream_strip_header.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_stream_strip_header
// Brief    : Removes a per-packet number of bytes from the head of an
//            AXI-Stream packet and re-packs the remainder onto full beats.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_cfg,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_cfg,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    pkt_dropped
);

    localparam logic [BYTE_CNT_WD-1:0] c_BEAT_BYTES = BYTE_CNT_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // r_n_eff is the byte offset of the tail kept from each beat; a zero strip
    // count is stored as a full-beat offset with r_pass set, so the residue is
    // always empty and every beat goes straight through.
    logic [BYTE_CNT_WD-1:0]  r_n_eff;
    logic                    r_pass;
    logic [DATA_WD-1:0]      r_res;
    logic [DATA_BYTE_WD-1:0] r_res_keep;

    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;
    logic                    r_drop;

    logic [DATA_WD-1:0]      w_din_m;
    logic [BYTE_CNT_WD-1:0]  w_rcnt;
    logic [BYTE_CNT_WD-1:0]  w_n_cfg;
    logic [DATA_WD-1:0]      w_str_data;
    logic [DATA_BYTE_WD-1:0] w_str_keep;
    logic [DATA_WD-1:0]      w_tail_data;
    logic [DATA_BYTE_WD-1:0] w_tail_keep;
    logic                    w_out_free;

    logic                    w_ready_cfg;
    logic                    w_ready_in;
    logic                    w_cfg_acc;
    logic                    w_ld;
    logic [DATA_WD-1:0]      w_ld_data;
    logic [DATA_BYTE_WD-1:0] w_ld_keep;
    logic                    w_ld_last;
    logic                    w_res_ld;
    logic                    w_drop;

    // Zero the bytes not flagged by keep so unused output bytes read as 0.
    for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_mask
        assign w_din_m[8*gi +: 8] = keep_in[gi] ? data_in[8*gi +: 8] : 8'h00;
    end

    assign w_n_cfg = ((byte_remove_cnt == '0) || (byte_remove_cnt > c_BEAT_BYTES))
                   ? c_BEAT_BYTES : byte_remove_cnt;

    // Residue holds r = W - n_eff bytes, left-aligned; incoming bytes slot in behind it.
    assign w_rcnt      = c_BEAT_BYTES - r_n_eff;
    assign w_str_data  = r_res | (w_din_m >> {w_rcnt, 3'b000});
    assign w_str_keep  = r_res_keep | (keep_in >> w_rcnt);
    assign w_tail_data = w_din_m << {r_n_eff, 3'b000};
    assign w_tail_keep = keep_in << r_n_eff;
    assign w_out_free  = !r_valid_out || ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready_cfg = 1'b0;
        w_ready_in  = 1'b0;
        w_cfg_acc   = 1'b0;
        w_ld        = 1'b0;
        w_ld_data   = w_str_data;
        w_ld_keep   = w_str_keep;
        w_ld_last   = 1'b0;
        w_res_ld    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_cfg = rst_n;
                if (valid_cfg && rst_n) begin
                    w_cfg_acc   = 1'b1;
                    w_state_nxt = FIRST;
                end
            end
            FIRST, STREAM: begin
                w_ready_in = w_out_free;
                if (valid_in && w_out_free) begin
                    w_res_ld = 1'b1;
                    if ((r_state == STREAM) || r_pass) begin
                        w_ld = 1'b1;
                        if (!last_in) begin
                            w_state_nxt = STREAM;
                        end else if (w_tail_keep == '0) begin
                            w_ld_last   = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = FLUSH;
                        end
                    end else if (!last_in) begin
                        w_state_nxt = STREAM;
                    end else if (w_tail_keep == '0) begin
                        w_drop      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ld        = 1'b1;
                        w_ld_data   = w_tail_data;
                        w_ld_keep   = w_tail_keep;
                        w_ld_last   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (w_out_free) begin
                    w_ld        = 1'b1;
                    w_ld_data   = r_res;
                    w_ld_keep   = r_res_keep;
                    w_ld_last   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_eff     <= '0;
            r_pass      <= 1'b0;
            r_res       <= '0;
            r_res_keep  <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            if (w_cfg_acc) begin
                r_n_eff    <= w_n_cfg;
                r_pass     <= (byte_remove_cnt == '0);
                r_res      <= '0;
                r_res_keep <= '0;
            end else if (w_res_ld) begin
                r_res      <= w_tail_data;
                r_res_keep <= w_tail_keep;
            end

            if (w_ld) begin
                r_valid_out <= 1'b1;
                r_data_out  <= w_ld_data;
                r_keep_out  <= w_ld_keep;
                r_last_out  <= w_ld_last;
            end else if (ready_out) begin
                r_valid_out <= 1'b0;
            end

            r_drop <= w_drop;
        end
    end

    assign ready_cfg   = w_ready_cfg;
    assign ready_in    = w_ready_in;
    assign valid_out   = r_valid_out;
    assign data_out    = r_data_out;
    assign keep_out    = r_keep_out;
    assign last_out    = r_last_out;
    assign pkt_dropped = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_strip_header.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_strip_header
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random packets against a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_strip_header;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_cfg;
    logic [CW-1:0] byte_remove_cnt;
    logic          ready_cfg;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out = 1'b1;
    logic          pkt_dropped;

    axi_stream_strip_header #(.DATA_WD(DW)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_cfg       (valid_cfg),
        .byte_remove_cnt (byte_remove_cnt),
        .ready_cfg       (ready_cfg),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .pkt_dropped     (pkt_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int              n;
        int              nb;
        logic [2:0][31:0] d;
        logic [2:0][3:0]  k;
        int              ne;
        logic [2:0][31:0] ed;
        logic [2:0][3:0]  ek;
        bit              drop;
    } vec_t;

    beat_t expq[$];
    bit    ro_script[$];
    int    ro_mode   = 0;
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    act_drops = 0;
    int    exp_drops = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    // ready_out: 0 = always ready, 1 = random, 2 = scripted sequence then ready
    initial forever begin
        @(negedge clk);
        if (ro_mode == 1)
            ready_out = ($urandom_range(0, 3) != 0);
        else if (ro_mode == 2 && ro_script.size() > 0)
            ready_out = ro_script.pop_front();
        else
            ready_out = 1'b1;
    end

    // Output monitor: scoreboard, hold-stability and stall back-pressure checks.
    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        beat_t       e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", valid_out, 1'b1);
                    chk("hold_data", data_out, pd);
                    chk("hold_keep", keep_out, pk);
                    chk("hold_last", last_out, pl);
                end
                if (valid_out && !ready_out)
                    chk("ready_in_stalled", ready_in, 1'b0);
                if (valid_out && ready_out) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat got=%h/%h last=%0b required=none",
                                 data_out, keep_out, last_out);
                    end else begin
                        e = expq.pop_front();
                        chk("out_data", data_out, e.data);
                        chk("out_keep", keep_out, e.keep);
                        chk("out_last", last_out, e.last);
                    end
                end
                if (pkt_dropped)
                    act_drops++;
                prev_stall = valid_out && !ready_out;
                pd = data_out;
                pk = keep_out;
                pl = last_out;
            end
        end
    end

    task automatic send_cfg(input int n);
        int t = 0;
        @(negedge clk);
        valid_cfg       = 1'b1;
        byte_remove_cnt = CW'(n);
        #1;
        while (!ready_cfg && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!ready_cfg) begin
            n_checks++;
            n_fail++;
            $display("FAIL cfg_timeout ready_cfg=%0b required=1", ready_cfg);
        end
        @(posedge clk);
        #1;
        valid_cfg = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit l);
        int t = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        #1;
        while (!ready_in && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!ready_in) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout ready_in=%0b required=1", ready_in);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (expq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain pending=%0d required=0", nm, expq.size());
            expq.delete();
        end
        repeat (3) @(negedge clk);
        chk("drop_count", act_drops, exp_drops);
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_keep_out", keep_out, 4'h0);
        chk("rst_last_out", last_out, 1'b0);
        chk("rst_ready_in", ready_in, 1'b0);
        chk("rst_ready_cfg", ready_cfg, 1'b0);
        chk("rst_pkt_dropped", pkt_dropped, 1'b0);
    endtask

    function automatic vec_t mk(input int n, input int nb,
                                input logic [31:0] d0, d1, d2, input logic [3:0] k0, k1, k2,
                                input int ne,
                                input logic [31:0] e0, e1, e2, input logic [3:0] f0, f1, f2,
                                input bit drop);
        vec_t v;
        v.n = n;   v.nb = nb;  v.ne = ne;  v.drop = drop;
        v.d[0] = d0;  v.d[1] = d1;  v.d[2] = d2;
        v.k[0] = k0;  v.k[1] = k1;  v.k[2] = k2;
        v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2;
        v.ek[0] = f0; v.ek[1] = f1; v.ek[2] = f2;
        return v;
    endfunction

    // Reference model: strip min(n,W) bytes from the packet's byte list and
    // re-chunk what remains into W-byte beats; an empty remainder is a drop.
    task automatic rand_pkt();
        int          n, nb, k, m, cnt;
        logic [7:0]  bq[$];
        logic [31:0] bd[$];
        logic [3:0]  bk[$];
        logic [31:0] d;
        logic [3:0]  kk;
        logic [7:0]  dummy;
        beat_t       b;
        n  = $urandom_range(0, 7);
        nb = $urandom_range(1, 4);
        k  = $urandom_range(1, 4);
        for (int i = 0; i < nb; i++) begin
            cnt = (i == nb - 1) ? k : 4;
            d   = $urandom;
            for (int j = 0; j < cnt; j++) bq.push_back(d[31-8*j -: 8]);
            kk = 4'hF << (4 - cnt);
            bd.push_back(d);
            bk.push_back(kk);
        end
        m = (n > 4) ? 4 : n;
        for (int i = 0; i < m; i++) if (bq.size() > 0) dummy = bq.pop_front();
        if (bq.size() == 0) exp_drops++;
        while (bq.size() > 0) begin
            b.data = '0;
            cnt = (bq.size() > 4) ? 4 : bq.size();
            for (int j = 0; j < cnt; j++) b.data[31-8*j -: 8] = bq.pop_front();
            b.keep = 4'hF << (4 - cnt);
            b.last = (bq.size() == 0);
            expq.push_back(b);
        end
        send_cfg(n);
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_beat(bd[i], bk[i], i == nb - 1);
        end
    endtask

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog elapsed=500000ns required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    vec_t  tbl[7];
    beat_t b;

    initial begin
        rst_n = 1'b0; valid_cfg = 1'b0; byte_remove_cnt = '0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_cfg_after_rst", ready_cfg, 1'b1);

        tbl[0] = mk(1, 3, 32'hAABBCCDD, 32'hEEFF0011, 32'h2233BEEF, 4'hF, 4'hF, 4'hC,
                    3, 32'hBBCCDDEE, 32'hFF001122, 32'h33000000, 4'hF, 4'hF, 4'h8, 1'b0);
        tbl[1] = mk(3, 1, 32'hAABB0000, 32'h0, 32'h0, 4'hC, 4'h0, 4'h0,
                    0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        tbl[2] = mk(4, 2, 32'h01020304, 32'h05060700, 32'h0, 4'hF, 4'hE, 4'h0,
                    1, 32'h05060700, 32'h0, 32'h0, 4'hE, 4'h0, 4'h0, 1'b0);
        tbl[3] = mk(2, 2, 32'h11223344, 32'h5566ABCD, 32'h0, 4'hF, 4'hC, 4'h0,
                    1, 32'h33445566, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 1'b0);
        tbl[4] = mk(0, 2, 32'h12345678, 32'h9ABCDEF0, 32'h0, 4'hF, 4'hC, 4'h0,
                    2, 32'h12345678, 32'h9ABC0000, 32'h0, 4'hF, 4'hC, 4'h0, 1'b0);
        tbl[5] = mk(7, 1, 32'h01020304, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0,
                    0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        tbl[6] = mk(3, 2, 32'hDEADBEEF, 32'h01020304, 32'h0, 4'hF, 4'h8, 4'h0,
                    1, 32'hEF010000, 32'h0, 32'h0, 4'hC, 4'h0, 4'h0, 1'b0);

        ro_mode = 1;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < tbl[i].ne; j++) begin
                b.data = tbl[i].ed[j];
                b.keep = tbl[i].ek[j];
                b.last = (j == tbl[i].ne - 1);
                expq.push_back(b);
            end
            if (tbl[i].drop) exp_drops++;
            send_cfg(tbl[i].n);
            for (int j = 0; j < tbl[i].nb; j++)
                send_beat(tbl[i].d[j], tbl[i].k[j], j == tbl[i].nb - 1);
            drain("vec");
            chk("ready_cfg_idle", ready_cfg, 1'b1);
        end

        // Pass-through with output stalled for two cycles after the first beat.
        ro_mode = 2;
        send_cfg(0);
        ro_script = '{1'b1, 1'b0, 1'b0, 1'b1};
        b.keep = 4'hF;
        b.data = 32'h0A0B0C0D; b.last = 1'b0; expq.push_back(b);
        b.data = 32'h10203040; b.last = 1'b0; expq.push_back(b);
        b.data = 32'h55667788; b.last = 1'b1; expq.push_back(b);
        send_beat(32'h0A0B0C0D, 4'hF, 1'b0);
        send_beat(32'h10203040, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hF, 1'b1);
        drain("bp");

        // Reset while a beat sits in the stalled output register.
        ro_script = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send_cfg(0);
        send_beat(32'hC0FFEE01, 4'hF, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", valid_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ro_mode = 0;
        ro_script.delete();
        @(negedge clk);
        #1;
        chk("ready_cfg_after_midrst", ready_cfg, 1'b1);
        b.keep = 4'hF; b.data = 32'h31323334; b.last = 1'b0; expq.push_back(b);
        b.keep = 4'h8; b.data = 32'h35000000; b.last = 1'b1; expq.push_back(b);
        send_cfg(0);
        send_beat(32'h31323334, 4'hF, 1'b0);
        send_beat(32'h35AAAAAA, 4'h8, 1'b1);
        drain("midrst");

        ro_mode = 1;
        repeat (40) rand_pkt();
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
